// File: rtl/llc_lookup_issue.sv
// Producer side of the LLC lookup FIFO: buffers lookup requests in order, reads the set
// arrays for each one and pushes complete packets, re-reading any set written while buffered.
module llc_lookup_issue #(
    parameter int LLC_WAYS       = 16,
    parameter int LLC_WAY_BITS   = 4,
    parameter int LLC_SET_BITS   = 9,
    parameter int LLC_TAG_BITS   = 15,
    parameter int LLC_STATE_BITS = 2,
    parameter int DEPTH          = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic [LLC_SET_BITS-1:0]                req_set,
    input  logic [LLC_TAG_BITS-1:0]                req_tag,
    output logic                                   mem_rd_en,
    output logic [LLC_SET_BITS-1:0]                mem_rd_set,
    input  logic [LLC_WAYS*LLC_TAG_BITS-1:0]       mem_rd_tags,
    input  logic [LLC_WAYS*LLC_STATE_BITS-1:0]     mem_rd_states,
    input  logic [LLC_WAY_BITS-1:0]                mem_rd_evict_way,
    input  logic                                   wr_en,
    input  logic [LLC_SET_BITS-1:0]                wr_set,
    input  logic                                   fifo_full_lookup,
    output logic                                   fifo_push_lookup,
    output logic [LLC_TAG_BITS+LLC_SET_BITS+LLC_WAYS*(LLC_TAG_BITS+LLC_STATE_BITS)+LLC_WAY_BITS-1:0] fifo_lookup_in
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DEPTH-1:0] valid_q, valid_d, data_ok_q, data_ok_d;
    logic [DEPTH-1:0] reread_q, reread_d, inflight_q, inflight_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, rd_idx_q, rd_idx_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             rd_pend_q, rd_pend_d;

    logic [LLC_SET_BITS-1:0]               set_q    [DEPTH];
    logic [LLC_TAG_BITS-1:0]               tag_q    [DEPTH];
    logic [LLC_WAYS*LLC_TAG_BITS-1:0]      tags_q   [DEPTH];
    logic [LLC_WAYS*LLC_STATE_BITS-1:0]    states_q [DEPTH];
    logic [LLC_WAY_BITS-1:0]               evict_q  [DEPTH];

    logic             rr_found, accept, push, cap;
    logic [PTR_W-1:0] rr_idx, scan_idx;

    // Oldest entry (from head) whose arrays went stale and has no read outstanding.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = head_q;
        scan_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (!rr_found && valid_q[scan_idx] && reread_q[scan_idx] && !inflight_q[scan_idx]) begin
                rr_found = 1'b1;
                rr_idx   = scan_idx;
            end
        end
    end

    assign req_ready  = (count_q < FULL_CNT) && !rr_found;
    assign accept     = req_valid && req_ready;
    assign mem_rd_en  = rr_found || accept;
    assign mem_rd_set = rr_found ? set_q[rr_idx] : req_set;
    assign push       = valid_q[head_q] && data_ok_q[head_q] && !fifo_full_lookup
                        && !(wr_en && (wr_set == set_q[head_q]));
    // Return data is kept only if no write touched the set since the read was issued.
    assign cap        = rd_pend_q && !reread_q[rd_idx_q]
                        && !(wr_en && (wr_set == set_q[rd_idx_q]));

    assign fifo_push_lookup = push;
    assign fifo_lookup_in   = (valid_q[head_q] && data_ok_q[head_q])
        ? {tag_q[head_q], set_q[head_q], tags_q[head_q], states_q[head_q], evict_q[head_q]}
        : '0;

    always_comb begin
        valid_d    = valid_q;
        data_ok_d  = data_ok_q;
        reread_d   = reread_q;
        inflight_d = inflight_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rd_pend_d  = mem_rd_en;
        rd_idx_d   = rr_found ? rr_idx : tail_q;

        if (rd_pend_q) begin
            inflight_d[rd_idx_q] = 1'b0;
            if (cap) data_ok_d[rd_idx_q] = 1'b1;
        end
        if (rr_found) begin
            reread_d[rr_idx]   = 1'b0;
            inflight_d[rr_idx] = 1'b1;
        end
        if (accept) begin
            valid_d[tail_q]    = 1'b1;
            data_ok_d[tail_q]  = 1'b0;
            reread_d[tail_q]   = wr_en && (wr_set == req_set);
            inflight_d[tail_q] = 1'b1;
            tail_d             = tail_q + PTR_ONE;
        end
        if (push) begin
            valid_d[head_q]   = 1'b0;
            data_ok_d[head_q] = 1'b0;
            head_d            = head_q + PTR_ONE;
        end
        // Write snoop comes last so it overrides a capture or a re-read clear this cycle.
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && valid_q[i] && (set_q[i] == wr_set)) begin
                data_ok_d[i] = 1'b0;
                reread_d[i]  = 1'b1;
            end
        end
        case ({accept, push})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            data_ok_q  <= '0;
            reread_q   <= '0;
            inflight_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_idx_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            data_ok_q  <= data_ok_d;
            reread_q   <= reread_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rd_pend_q  <= rd_pend_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    // Payload storage carries no reset; it is only observed behind valid/data_ok.
    always_ff @(posedge clk) begin
        if (accept) begin
            set_q[tail_q] <= req_set;
            tag_q[tail_q] <= req_tag;
        end
        if (cap) begin
            tags_q[rd_idx_q]   <= mem_rd_tags;
            states_q[rd_idx_q] <= mem_rd_states;
            evict_q[rd_idx_q]  <= mem_rd_evict_way;
        end
    end
endmodule
